// File: rtl/fp_add_result_buffer.sv
// Result buffer behind the bfloat16 adder: FIFO of {sum, flags},
// cumulative sticky exception flags and a saturating result counter.
module fp_add_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_sum,
    input  logic                       in_underflow,
    input  logic                       in_overflow,
    input  logic                       in_inexact,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_sum,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [2:0]                 sticky_flags,
    input  logic                       flags_clear,
    output logic [CNT_W-1:0]           result_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 19;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic          push;
    logic          pop;
    logic [2:0]    in_flags;
    logic [EW-1:0] head;

    assign in_flags  = {in_overflow, in_underflow, in_inexact};
    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy is tracked explicitly so full and empty never alias.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // A clear coinciding with a flagged push keeps that push's flags.
    always_comb begin
        sticky_d = flags_clear ? 3'b000 : sticky_q;
        if (push) begin
            sticky_d = sticky_d | in_flags;
        end
        count_d = count_q;
        if (push && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared so the head read is never X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {in_sum, in_flags};
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign out_sum      = head[EW-1:3];
    assign out_flags    = head[2:0];
    assign level        = level_q;
    assign sticky_flags = sticky_q;
    assign result_count = count_q;

endmodule
